// File: rtl/srl_var_delay.sv
// srl_var_delay: multi-bit shift-register delay line with a runtime-selectable
// delay of 1..MAX_DEPTH enabled clocks, plus an optional output register.
//
// Ports:
//   iclk   - clock, all logic on the rising edge
//   irst   - asynchronous active-high reset
//   ice    - clock enable for the shift array, output register and fill counter
//   id     - input data word
//   idelay - requested delay in enabled clocks (0 clamps to 1, >MAX_DEPTH clamps to MAX_DEPTH)
//   oq     - delayed data
//   ovalid - line has refilled since the last reset or delay change
//   odelay - effective delay currently applied
module srl_var_delay #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_DEPTH = 64,
   parameter int unsigned OREG      = 1,
   localparam int unsigned DW       = $clog2(MAX_DEPTH + 1)
) (
   input  logic             iclk,
   input  logic             irst,
   input  logic             ice,
   input  logic [WIDTH-1:0] id,
   input  logic [DW-1:0]    idelay,
   output logic [WIDTH-1:0] oq,
   output logic             ovalid,
   output logic [DW-1:0]    odelay
);

   localparam int unsigned FW = $clog2(MAX_DEPTH + 2);
   localparam int unsigned AW = $clog2(MAX_DEPTH);

   logic [WIDTH-1:0] sr [MAX_DEPTH];
   logic [DW-1:0]    dly_c;
   logic [DW-1:0]    dly_r;
   logic [FW-1:0]    fcnt;
   logic [FW-1:0]    tgt_c;
   logic [AW-1:0]    tap_idx_c;
   logic [WIDTH-1:0] tap_c;
   logic             chg_c;

   // Shift array carries no reset so it maps onto SRL primitives
   always_ff @(posedge iclk) begin
      if (ice) begin
         sr[0] <= id;
         for (int k = 1; k < MAX_DEPTH; k++) begin
            sr[k] <= sr[k-1];
         end
      end
   end

   // Clamp the requested delay into 1..MAX_DEPTH
   always_comb begin
      dly_c = idelay;
      if (idelay == '0) begin
         dly_c = DW'(1);
      end else if (idelay > DW'(MAX_DEPTH)) begin
         dly_c = DW'(MAX_DEPTH);
      end
   end

   // Delay capture runs every edge so a change is seen even while ice is low
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         dly_r <= DW'(MAX_DEPTH);
      end else begin
         dly_r <= dly_c;
      end
   end

   assign chg_c     = (dly_c != dly_r);
   assign tgt_c     = FW'(dly_r) + FW'(OREG);
   assign tap_idx_c = AW'(dly_r - DW'(1));
   assign tap_c     = sr[tap_idx_c];

   // Fill counter: a delay change restarts the refill, even on an enabled edge
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         fcnt <= '0;
      end else if (chg_c) begin
         fcnt <= '0;
      end else if (ice && (fcnt < tgt_c)) begin
         fcnt <= fcnt + FW'(1);
      end
   end

   // A pending change masks valid immediately, before the counter clears
   assign ovalid = (fcnt == tgt_c) && !chg_c;
   assign odelay = dly_r;

   generate
      if (OREG != 0) begin : g_oreg
         always_ff @(posedge iclk or posedge irst) begin
            if (irst) begin
               oq <= '0;
            end else if (ice) begin
               oq <= tap_c;
            end
         end
      end else begin : g_noreg
         assign oq = tap_c;
      end
   endgenerate

endmodule

// File: tb/tb_srl_var_delay.sv
// tb_srl_var_delay: randomized and directed stimulus for two srl_var_delay
// instances (registered and unregistered output) sharing the same inputs,
// checked through a scoreboard against a word-history reference model.
module tb_srl_var_delay;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned MAXD  = 64;
   localparam int unsigned DW    = $clog2(MAXD + 1);

   typedef struct {
      int         dly;
      bit         v1;
      bit         v0;
      logic [7:0] q1;
      logic [7:0] q0;
   } exp_t;

   logic             iclk;
   logic             irst;
   logic             ice;
   logic [WIDTH-1:0] id;
   logic [DW-1:0]    idelay;
   logic [WIDTH-1:0] oq1, oq0;
   logic             ovalid1, ovalid0;
   logic [DW-1:0]    odelay1, odelay0;

   srl_var_delay #(.WIDTH(WIDTH), .MAX_DEPTH(MAXD), .OREG(1)) dut1 (
      .iclk(iclk), .irst(irst), .ice(ice), .id(id), .idelay(idelay),
      .oq(oq1), .ovalid(ovalid1), .odelay(odelay1));

   srl_var_delay #(.WIDTH(WIDTH), .MAX_DEPTH(MAXD), .OREG(0)) dut0 (
      .iclk(iclk), .irst(irst), .ice(ice), .id(id), .idelay(idelay),
      .oq(oq0), .ovalid(ovalid0), .odelay(odelay0));

   initial begin
      iclk = 1'b0;
      forever #5 iclk = ~iclk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   exp_t       sbq[$];
   logic [7:0] hist[$];   // word accepted at each enabled edge, oldest first
   int         m_cnt = 0; // enabled edges so far
   int         m_dly = MAXD;
   int         m_fs  = 0; // enabled-edge count when the current fill began
   logic [7:0] ctr   = 8'h00;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampd(input int r);
      if (r == 0) return 1;
      if (r > int'(MAXD)) return int'(MAXD);
      return r;
   endfunction

   // Drive one clock worth of inputs, advance the model across the coming edge
   task automatic cycle(input bit ce, input logic [7:0] d, input int dl, input bit do_rst);
      exp_t e;
      int   run;
      @(negedge iclk);
      if (do_rst) begin
         #1 irst = 1'b1;
         #1;
         chk("rst_oq1", int'(oq1), 0);
         chk("rst_valid1", int'(ovalid1), 0);
         chk("rst_valid0", int'(ovalid0), 0);
         chk("rst_odelay", int'(odelay1), int'(MAXD));
         #1 irst = 1'b0;
         m_dly = MAXD;
         m_fs  = m_cnt;
      end
      ice    = ce;
      id     = d;
      idelay = DW'(dl);
      if (ce) begin
         hist.push_back(d);
         m_cnt++;
      end
      if (clampd(dl) != m_dly) begin
         m_dly = clampd(dl);
         m_fs  = m_cnt;
      end
      run   = m_cnt - m_fs;
      e.dly = m_dly;
      e.v1  = (run >= m_dly + 1);
      e.v0  = (run >= m_dly);
      e.q1  = e.v1 ? hist[m_cnt - 1 - m_dly] : 8'h00;
      e.q0  = e.v0 ? hist[m_cnt - m_dly] : 8'h00;
      sbq.push_back(e);
   endtask

   // Monitor: every output state after an edge is compared to the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge iclk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("odelay1", int'(odelay1), e.dly);
            chk("odelay0", int'(odelay0), e.dly);
            chk("ovalid1", int'(ovalid1), int'(e.v1));
            chk("ovalid0", int'(ovalid0), int'(e.v0));
            if (e.v1) chk("oq1", int'(oq1), int'(e.q1));
            if (e.v0) chk("oq0", int'(oq0), int'(e.q0));
         end
      end
   end

   initial begin
      int dl;
      irst   = 1'b1;
      ice    = 1'b0;
      id     = '0;
      idelay = '0;
      #12;
      chk("init_oq1", int'(oq1), 0);
      chk("init_valid1", int'(ovalid1), 0);
      chk("init_valid0", int'(ovalid0), 0);
      chk("init_odelay", int'(odelay1), int'(MAXD));
      irst = 1'b0;

      // Steady delay 5, continuous enable, counting data
      for (int i = 0; i < 40; i++) begin cycle(1'b1, ctr, 5, 1'b0); ctr++; end
      // Enable toggling every cycle
      for (int i = 0; i < 40; i++) begin
         cycle(bit'(i % 2 == 0), ctr, 5, 1'b0);
         if (i % 2 == 0) ctr++;
      end
      // Clamp low and high
      for (int i = 0; i < 20; i++) begin cycle(1'b1, ctr, 0, 1'b0); ctr++; end
      for (int i = 0; i < 150; i++) begin cycle(1'b1, ctr, 100, 1'b0); ctr++; end
      // Shorten the delay mid-stream
      for (int i = 0; i < 20; i++) begin cycle(1'b1, ctr, 5, 1'b0); ctr++; end
      for (int i = 0; i < 20; i++) begin cycle(1'b1, ctr, 3, 1'b0); ctr++; end
      // Reset pulse mid-stream with delay 64 held
      for (int i = 0; i < 80; i++) begin cycle(1'b1, ctr, 64, 1'b0); ctr++; end
      cycle(1'b1, ctr, 64, 1'b1); ctr++;
      for (int i = 0; i < 150; i++) begin cycle(1'b1, ctr, 64, 1'b0); ctr++; end
      // Minimum delay
      for (int i = 0; i < 20; i++) begin cycle(1'b1, ctr, 1, 1'b0); ctr++; end
      // Delay change while disabled
      for (int i = 0; i < 6; i++) cycle(1'b0, ctr, 2, 1'b0);
      for (int i = 0; i < 10; i++) begin cycle(1'b1, ctr, 2, 1'b0); ctr++; end
      // Random traffic, occasional delay changes and resets
      dl = 7;
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 49) == 0) dl = int'($urandom_range(0, 127));
         else if ($urandom_range(0, 49) == 0) dl = int'($urandom_range(0, 12));
         cycle(bit'($urandom_range(0, 3) != 0), 8'($urandom), dl,
               bit'($urandom_range(0, 299) == 0));
      end

      repeat (3) @(negedge iclk);
      chk("sb_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/srl_var_delay.md
Name: srl_var_delay

Overview:
- Parameterised multi-bit delay line with a runtime-selectable delay: 1..MAX_DEPTH enabled clocks, plus an optional output register.
- Successor to the fixed single-bit N-stage shift-register delay line.
- Adds bus width, clock enable, dynamic tap selection and a primed/valid indicator.
- Used for aligning data buses against variable-latency pipelines (e.g. DSP paths whose latency is configured at runtime).

Parameters:
- WIDTH, 8, data bus width in bits (>=1).
- MAX_DEPTH, 64, number of shift stages and maximum selectable delay (>=2).
- OREG, 1, 1 = registered output (adds one enabled clock of latency); 0 = output taken directly from the tap mux.
- DW, $clog2(MAX_DEPTH+1), width of the delay-select port; derived, not to be overridden.

Ports:
- iclk  input  1  clock; all logic on the rising edge.
- irst  input  1  asynchronous, active-high reset.
- ice  input  1  clock enable; shift, output register and fill counter advance only when 1.
- id  input  WIDTH  input data.
- idelay  input  DW  requested delay in enabled clocks, excluding OREG.
- oq  output  WIDTH  delayed data.
- ovalid  output  1  1 when the line has been filled since the last reset or delay change, i.e. oq reflects real input data.
- odelay  output  DW  effective (clamped, captured) delay currently applied.

Behaviour:
- Shift array sr[0..MAX_DEPTH-1] has no reset, so it stays SRL-inferable.
  - On iclk rising with ice=1: sr[0]<=id; sr[k]<=sr[k-1].
  - With ice=0 the array holds.
- Delay capture:
  - Clamp: dly_c = 1 if idelay==0; MAX_DEPTH if idelay>MAX_DEPTH; otherwise idelay.
  - Internal register dly_r (reset value MAX_DEPTH) samples dly_c on every iclk edge, independent of ice.
  - odelay = dly_r.
- Tap:
  - tap = sr[dly_r-1], a combinational mux.
  - OREG=1: oq register loads tap when ice=1; reset value 0.
  - OREG=0: oq = tap. The data is undefined until ovalid; the bench must not check it then.
- Latency: a word presented on id at enabled edge n appears on oq after enabled edge n+dly_r-1 (OREG=0) or n+dly_r (OREG=1). Disabled clocks do not count.
- Fill counter fcnt:
  - Width $clog2(MAX_DEPTH+2); reset value 0.
  - Target T = dly_r + OREG.
  - Change event: dly_c != dly_r at an edge. The counter clears to 0 on that edge, with priority over increment even if ice=1.
  - Otherwise, when ice=1 and fcnt<T, fcnt increments; it saturates at T.
  - ovalid = (fcnt==T) and no pending change, as a combinational compare. Reset value 0.
- Delay change mid-stream:
  - Data in sr is not flushed; the new tap takes effect on the cycle after capture.
  - ovalid drops for T enabled clocks, then reasserts.
  - Changing to a shorter delay still requires a full T refill. This is conservative by decision.
- Reset mid-operation:
  - oq=0 (OREG=1), ovalid=0, fcnt=0, dly_r=MAX_DEPTH, all immediately (asynchronous).
  - sr retains its contents.
  - After irst deasserts, dly_r captures dly_c on the first edge. If it differs from MAX_DEPTH this is a change event, and fcnt stays 0.
- ice held 0 indefinitely: oq, ovalid and fcnt are frozen. A delay change still clears fcnt and ovalid.
- No combinational path from id to oq in either OREG mode (minimum delay 1).

Test Plan:
- WIDTH=8, MAX_DEPTH=64, OREG=1, idelay=5, ice=1, id=counter 0,1,2..., reset released at cycle 0 -> ovalid rises after the 6th enabled edge; oq then equals id from 6 edges earlier (oq=0x00 when id=0x06), continuously.
- Same configuration, ice toggled 1/0 every cycle -> oq sequence identical to the previous test over enabled edges only; oq and ovalid stable on disabled edges.
- idelay=0 -> odelay=1, oq lags id by 2 edges. idelay=100 -> odelay=64, ovalid after 65 enabled edges.
- Running at idelay=5 with ovalid=1, switch to idelay=3 -> ovalid=0 for exactly 4 enabled edges; afterwards oq lags id by 4 edges.
- irst pulsed for 1 cycle mid-stream (asynchronously, between edges) -> oq=0 and ovalid=0 immediately. With idelay=64 held, ovalid returns after 65 enabled edges.
- OREG=0, idelay=1 -> oq equals id sampled at the previous enabled edge; ovalid after 1 enabled edge.
